// File: rtl/pipe_stage_if.sv
// pipe_stage_if -- payload handshake bundle for pipe_stage.
//
// Handshake rule for both the in_* and the out_* channel: a transfer
// happens on a rising clk edge where valid & ready are both 1. Once the
// producer raises valid it keeps valid and data stable until the transfer
// happens (or a flush/reset discards it). The consumer may drive ready
// independently of valid.
//
// Signals:
//   in_valid   upstream payload valid            (master -> stage)
//   in_ready   stage accepts payload this cycle  (stage -> master)
//   in_data    upstream payload, WIDTH bits      (master -> stage)
//   out_valid  downstream payload valid          (stage -> master)
//   out_ready  downstream accepts this cycle     (master -> stage)
//   out_data   downstream payload, WIDTH bits    (stage -> master)
//
// Modports:
//   slave   the pipe_stage side
//   master  the surrounding logic (upstream producer + downstream consumer)
interface pipe_stage_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage -- one valid/ready pipeline register stage with flush and a
// saturating output-stall counter.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   : main entry + skid entry; in_ready is a
//                                   flop output ("skid entry empty"), so no
//                                   combinational path out_ready -> in_ready.
//                       undefined : single entry; in_ready = ~out_valid | out_ready.
//   Both modes sustain one payload per cycle.
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous flush: drops every held payload and any input
//              offered that cycle; payload registers keep their contents
//   cnt_clr    synchronous clear of stall_cnt (wins over an increment)
//   bus        pipe_stage_if.slave handshake bundle (in_*/out_*)
//   stall_cnt  count of cycles with out_valid & ~out_ready, saturating
module pipe_stage #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        cnt_clr,
    pipe_stage_if.slave bus,
    output logic [15:0] stall_cnt
);

    // Main entry: the register that drives out_data/out_valid directly.
    logic             mainValid;
    logic [WIDTH-1:0] mainData;

    logic inXfer;
    logic outXfer;
    logic stallNow;

    assign inXfer   = bus.in_valid & bus.in_ready;
    assign outXfer  = mainValid & bus.out_ready;
    assign stallNow = mainValid & ~bus.out_ready;

    assign bus.out_valid = mainValid;
    assign bus.out_data  = mainData;

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry catches the one payload that may arrive while main is
    // full and stalled, because in_ready is only updated at the next edge.
    logic             skidValid;
    logic [WIDTH-1:0] skidData;

    assign bus.in_ready = ~skidValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainData  <= RST_VAL;
            skidData  <= RST_VAL;
        end else if (flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (outXfer) begin
            // Main drains: refill from skid first to keep acceptance order.
            // in_ready is low whenever skid is full, so inXfer cannot
            // coincide with the skid-to-main move.
            if (skidValid) begin
                mainData  <= skidData;
                skidValid <= 1'b0;
            end else if (inXfer) begin
                mainData <= bus.in_data;
            end else begin
                mainValid <= 1'b0;
            end
        end else if (inXfer) begin
            if (mainValid) begin
                skidData  <= bus.in_data;
                skidValid <= 1'b1;
            end else begin
                mainData  <= bus.in_data;
                mainValid <= 1'b1;
            end
        end
    end
`else
    assign bus.in_ready = ~mainValid | bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainValid <= 1'b0;
            mainData  <= RST_VAL;
        end else if (flush) begin
            mainValid <= 1'b0;
        end else if (inXfer) begin
            // Covers both "empty" and "draining and refilling" cases.
            mainData  <= bus.in_data;
            mainValid <= 1'b1;
        end else if (outXfer) begin
            mainValid <= 1'b0;
        end
    end
`endif

    // Stall counter: independent of flush; clear has priority; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (cnt_clr) begin
            stall_cnt <= 16'd0;
        end else if (stallNow && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
